// File: rtl/i2c_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter_if
// Bundles the requester-side and I2C-core-side signals of i2c_bus_arbiter.
//   req_*            : per-requester transaction requests (packed, 8 bits/requester)
//   grant_o/done_o   : one-hot ownership and completion pulse back to requesters
//   err_o/rdata_o    : completion status and last captured read byte
//   i2c_*_i          : status coming back from the single I2C master core
//   i2c_*_o          : strobes and latched transaction fields going to the core
// Modports:
//   master : the arbiter's view (drives grant/done/err/rdata and the core inputs)
//   slave  : the environment's view (requesters plus the I2C core)
// ---------------------------------------------------------------------------
interface i2c_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ-1:0]   req_rnw_i;
  logic [8*N_REQ-1:0] req_slave_addr_i;
  logic [8*N_REQ-1:0] req_command_byte_i;
  logic [8*N_REQ-1:0] req_din_i;
  logic [8*N_REQ-1:0] req_num_bytes_i;
  logic [N_REQ-1:0]   grant_o;
  logic [N_REQ-1:0]   done_o;
  logic               err_o;
  logic [7:0]         rdata_o;

  logic               i2c_busy_i;
  logic               i2c_rxak_i;
  logic               i2c_arb_lost_i;
  logic               i2c_data_out_valid_i;
  logic [7:0]         i2c_data_out_i;
  logic               i2c_write_o;
  logic               i2c_read_o;
  logic [7:0]         i2c_slave_addr_o;
  logic [7:0]         i2c_command_byte_o;
  logic [7:0]         i2c_din_o;
  logic [7:0]         i2c_num_bytes_o;

  modport master (
    input  req_i, req_rnw_i, req_slave_addr_i, req_command_byte_i,
           req_din_i, req_num_bytes_i,
           i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_valid_i,
           i2c_data_out_i,
    output grant_o, done_o, err_o, rdata_o,
           i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_command_byte_o,
           i2c_din_o, i2c_num_bytes_o
  );

  modport slave (
    output req_i, req_rnw_i, req_slave_addr_i, req_command_byte_i,
           req_din_i, req_num_bytes_i,
           i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_valid_i,
           i2c_data_out_i,
    input  grant_o, done_o, err_o, rdata_o,
           i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_command_byte_o,
           i2c_din_o, i2c_num_bytes_o
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one I2C master core between N_REQ requesters. The bus is granted
// round-robin, one complete transaction at a time: the owner's fields are
// latched onto the core inputs, a single read/write strobe is issued, and the
// core's busy rise/fall handshake is tracked. The owner then gets a one-cycle
// done pulse together with err_o and the last captured read byte.
// Ports:
//   clk_i    : clock
//   reset_i  : asynchronous active-high reset (aborts any transaction, no done)
//   bus      : i2c_bus_arbiter_if.master (requester and I2C-core signals)
// Parameters:
//   N_REQ         : number of requesters (2..8)
//   START_TIMEOUT : cycles to wait for busy to rise after the strobe
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int N_REQ         = 2,
  parameter int START_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  i2c_bus_arbiter_if.master      bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_END,
    S_COMPLETE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               err_q;
  logic [7:0]         rdata_q;
  logic               write_q;
  logic               read_q;
  logic               rnw_q;
  logic [7:0]         addr_q;
  logic [7:0]         cmd_q;
  logic [7:0]         din_q;
  logic [7:0]         num_q;
  logic [TMR_W-1:0]   timer_q;
  logic               arb_err_q;

  logic [IDX_W-1:0]   pick_d;
  logic [TMR_W-1:0]   timer_d;

  // Round-robin search starting just above the previous owner. Offsets are
  // scanned from farthest to nearest so the nearest requesting index wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] last);
    int idx;
    rr_pick = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) rr_pick = IDX_W'(idx);
    end
  endfunction

  assign pick_d  = rr_pick(bus.req_i, last_q);
  assign timer_d = timer_q + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      cmd_q     <= '0;
      din_q     <= '0;
      num_q     <= '0;
      timer_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      // Strobes and the done/err pair are single-cycle; default them low.
      write_q <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A busy core here means another master owns the wire; hold off.
          if (!bus.i2c_busy_i && (bus.req_i != '0)) begin
            grant_q <= N_REQ'(1) << pick_d;
            last_q  <= pick_d;
            rnw_q   <= bus.req_rnw_i[pick_d];
            addr_q  <= bus.req_slave_addr_i[{pick_d, 3'b000} +: 8];
            cmd_q   <= bus.req_command_byte_i[{pick_d, 3'b000} +: 8];
            din_q   <= bus.req_din_i[{pick_d, 3'b000} +: 8];
            num_q   <= bus.req_num_bytes_i[{pick_d, 3'b000} +: 8];
            // The strobe is registered here so it is high for the ISSUE cycle.
            read_q  <= bus.req_rnw_i[pick_d];
            write_q <= ~bus.req_rnw_i[pick_d];
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          timer_q   <= '0;
          arb_err_q <= 1'b0;
          state_q   <= S_WAIT_START;
        end

        S_WAIT_START: begin
          if (bus.i2c_busy_i) begin
            state_q <= S_WAIT_END;
          end else if (timer_d == TMR_W'(START_TIMEOUT)) begin
            done_q  <= grant_q;
            err_q   <= 1'b1;
            state_q <= S_COMPLETE;
          end else begin
            timer_q <= timer_d;
          end
        end

        S_WAIT_END: begin
          if (bus.i2c_arb_lost_i) arb_err_q <= 1'b1;
          if (bus.i2c_data_out_valid_i) rdata_q <= bus.i2c_data_out_i;
          if (!bus.i2c_busy_i) begin
            // On a read the final rxak is the master's own NACK, not an error.
            done_q  <= grant_q;
            err_q   <= arb_err_q | bus.i2c_arb_lost_i | (bus.i2c_rxak_i & ~rnw_q);
            state_q <= S_COMPLETE;
          end
        end

        S_COMPLETE: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o            = grant_q;
  assign bus.done_o             = done_q;
  assign bus.err_o              = err_q;
  assign bus.rdata_o            = rdata_q;
  assign bus.i2c_write_o        = write_q;
  assign bus.i2c_read_o         = read_q;
  assign bus.i2c_slave_addr_o   = addr_q;
  assign bus.i2c_command_byte_o = cmd_q;
  assign bus.i2c_din_o          = din_q;
  assign bus.i2c_num_bytes_o    = num_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed and randomized transactions against i2c_bus_arbiter, with a small
// I2C-core responder and a round-robin/outcome model kept in the bench.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;
  localparam int N  = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst;

  i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

  i2c_bus_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         last_m;
  logic [7:0] rdata_m;
  logic       rnw_m  [N];
  logic [7:0] addr_m [N];
  logic [7:0] cmd_m  [N];
  logic [7:0] din_m  [N];
  logic [7:0] num_m  [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] req, input int last);
    for (int s = 1; s <= N; s++)
      if (req[(last + s) % N]) return (last + s) % N;
    return -1;
  endfunction

  task automatic drive_fields();
    for (int k = 0; k < N; k++) begin
      bus.req_rnw_i[k]                = rnw_m[k];
      bus.req_slave_addr_i[8*k +: 8]   = addr_m[k];
      bus.req_command_byte_i[8*k +: 8] = cmd_m[k];
      bus.req_din_i[8*k +: 8]          = din_m[k];
      bus.req_num_bytes_i[8*k +: 8]    = num_m[k];
    end
  endtask

  task automatic set_req(input int k, input logic rnw, input logic [7:0] a,
                         input logic [7:0] c, input logic [7:0] d, input logic [7:0] n);
    rnw_m[k] = rnw; addr_m[k] = a; cmd_m[k] = c; din_m[k] = d; num_m[k] = n;
    drive_fields();
    bus.req_i[k] = 1'b1;
  endtask

  task automatic core_idle();
    bus.i2c_busy_i           = 1'b0;
    bus.i2c_rxak_i           = 1'b0;
    bus.i2c_arb_lost_i       = 1'b0;
    bus.i2c_data_out_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant_o), 32'd0);
    chk({tag, "_done"},  32'(bus.done_o), 32'd0);
    chk({tag, "_err"},   32'(bus.err_o), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata_o), 32'd0);
    chk({tag, "_wr"},    32'(bus.i2c_write_o), 32'd0);
    chk({tag, "_rd"},    32'(bus.i2c_read_o), 32'd0);
    chk({tag, "_addr"},  32'(bus.i2c_slave_addr_o), 32'd0);
    chk({tag, "_cmd"},   32'(bus.i2c_command_byte_o), 32'd0);
    chk({tag, "_din"},   32'(bus.i2c_din_o), 32'd0);
    chk({tag, "_num"},   32'(bus.i2c_num_bytes_o), 32'd0);
  endtask

  // One transaction. d = negedge index at which busy goes high (d<0: never),
  // L = busy length, arb_c = negedge index of an arb_lost pulse (<0: none),
  // nvalid = number of valid data cycles starting at d+1, force_last >= 0 pins
  // the final byte. mode: 0 drop granted req at done, 1 hold all, 2 drop all.
  task automatic run_one(input int d, input int L, input int arb_c, input logic rxak,
                         input int nvalid, input int force_last, input int mode);
    int k, c, strobes, done_c;
    logic seen, exp_err;
    logic [7:0] dat;
    k = rr_model(bus.req_i, last_m);
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.grant_o != '0) begin seen = 1'b1; break; end
    end
    chk("grant_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("grant",  32'(bus.grant_o), 32'(1 << k));
    chk("rd_strobe", 32'(bus.i2c_read_o), 32'(rnw_m[k]));
    chk("wr_strobe", 32'(bus.i2c_write_o), 32'(!rnw_m[k]));
    chk("addr", 32'(bus.i2c_slave_addr_o), 32'(addr_m[k]));
    chk("cmd",  32'(bus.i2c_command_byte_o), 32'(cmd_m[k]));
    chk("din",  32'(bus.i2c_din_o), 32'(din_m[k]));
    chk("num",  32'(bus.i2c_num_bytes_o), 32'(num_m[k]));
    last_m  = k;
    exp_err = (d < 0) || (arb_c >= 0) || (rxak && !rnw_m[k]);
    done_c  = (d < 0) ? TO + 1 : d + L + 1;
    strobes = 1;
    c = 0;
    seen = 1'b0;
    core_idle();
    bus.i2c_rxak_i = rxak;
    while (!seen && c <= done_c + 5) begin
      @(negedge clk);
      c++;
      if (bus.i2c_write_o || bus.i2c_read_o) strobes++;
      if (bus.done_o != '0) begin
        seen = 1'b1;
      end else begin
        bus.i2c_busy_i           = (d > 0) && (c >= d) && (c < d + L);
        bus.i2c_arb_lost_i       = (c == arb_c);
        dat                      = 8'($urandom);
        bus.i2c_data_out_valid_i = (d > 0) && (c >= d + 1) && (c <= d + nvalid);
        if (bus.i2c_data_out_valid_i) begin
          if (c == d + nvalid && force_last >= 0) dat = 8'(force_last);
          rdata_m = dat;
        end
        bus.i2c_data_out_i = dat;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("done_cycle", 32'(c), 32'(done_c));
      chk("done",   32'(bus.done_o), 32'(1 << k));
      chk("err",    32'(bus.err_o), 32'(exp_err));
      chk("rdata",  32'(bus.rdata_o), 32'(rdata_m));
      chk("strobes", 32'(strobes), 32'd1);
    end
    if (mode == 0) bus.req_i[k] = 1'b0;
    else if (mode == 2) bus.req_i = '0;
    core_idle();
    @(negedge clk);
    chk("idle_grant", 32'(bus.grant_o), 32'd0);
    chk("idle_done",  32'(bus.done_o), 32'd0);
  endtask

  initial begin
    int d, L, arb_c, nv;
    logic seen;
    rst = 1'b1;
    bus.req_i = '0;
    for (int k = 0; k < N; k++) begin
      rnw_m[k] = 1'b0; addr_m[k] = '0; cmd_m[k] = '0; din_m[k] = '0; num_m[k] = '0;
    end
    drive_fields();
    core_idle();
    bus.i2c_data_out_i = 8'h00;
    last_m  = N - 1;
    rdata_m = 8'h00;

    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Foreign activity: busy high in IDLE blocks the grant.
    bus.i2c_busy_i = 1'b1;
    set_req(0, 1'b0, 8'hD0, 8'h6B, 8'h00, 8'h02);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("foreign_busy_grant", 32'(bus.grant_o), 32'd0);
    end
    bus.i2c_busy_i = 1'b0;

    // Requester 0 write.
    run_one(1, 5, -1, 1'b0, 0, -1, 0);

    // Requester 1 read with a final master NACK.
    set_req(1, 1'b1, 8'hD0, 8'h3D, 8'h00, 8'h02);
    run_one(1, 4, -1, 1'b1, 1, 8'hF9, 0);

    // Two requesters held high: grants alternate 0,1,0,1.
    set_req(0, 1'b0, 8'hA0, 8'h11, 8'h22, 8'h02);
    set_req(1, 1'b0, 8'hA2, 8'h33, 8'h44, 8'h02);
    run_one(1, 2, -1, 1'b0, 0, -1, 1);
    run_one(2, 3, -1, 1'b0, 0, -1, 1);
    run_one(1, 1, -1, 1'b0, 0, -1, 1);
    run_one(3, 2, -1, 1'b0, 0, -1, 2);

    // Arbitration lost mid-transfer.
    set_req(0, 1'b0, 8'hD0, 8'h01, 8'h5A, 8'h02);
    run_one(2, 5, 4, 1'b0, 0, -1, 0);

    // Write NACKed by the slave.
    set_req(1, 1'b0, 8'hD2, 8'h02, 8'hA5, 8'h02);
    run_one(1, 3, -1, 1'b1, 0, -1, 0);

    // Busy never rises.
    set_req(2, 1'b1, 8'hEE, 8'h7F, 8'h00, 8'h01);
    run_one(-1, 0, -1, 1'b0, 0, -1, 0);

    // Reset asserted during WAIT_END aborts without a done pulse.
    set_req(0, 1'b1, 8'h90, 8'h0F, 8'h00, 8'h02);
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.grant_o != '0) begin seen = 1'b1; break; end
    end
    chk("abort_grant", 32'(bus.grant_o), 32'd1);
    @(negedge clk);
    bus.i2c_busy_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    chk("reset_no_done", 32'(bus.done_o), 32'd0);
    bus.i2c_busy_i = 1'b0;
    rst = 1'b0;
    last_m  = N - 1;
    rdata_m = 8'h00;
    set_req(1, 1'b0, 8'h92, 8'h10, 8'h01, 8'h02);
    run_one(1, 2, -1, 1'b0, 0, -1, 0);
    run_one(2, 2, -1, 1'b0, 0, -1, 0);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.req_i[k] && ($urandom_range(1, 0) == 1))
          set_req(k, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      if (bus.req_i == '0) begin
        int k0;
        k0 = int'($urandom_range(N - 1, 0));
        set_req(k0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      if ($urandom_range(7, 0) == 0) begin
        run_one(-1, 0, -1, 1'($urandom), 0, -1, 0);
      end else begin
        d     = int'($urandom_range(4, 1));
        L     = int'($urandom_range(6, 1));
        arb_c = ($urandom_range(3, 0) == 0) ? int'($urandom_range(d + L, d + 1)) : -1;
        nv    = int'($urandom_range(L, 0));
        run_one(d, L, arb_c, 1'($urandom), nv, -1, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master core between N_REQ transaction requesters, e.g. the bubble-level FSM plus a second sensor poller.
- Grants the bus round-robin, one whole transaction at a time.
- Drives the core's strobe, address and command inputs, then waits for the busy start/end handshake.
- Returns a per-requester done pulse with error status and the captured read byte.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- START_TIMEOUT, 255: cycles to wait for i2c_busy_i to rise after a strobe before declaring an error.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  level request per requester; held high until its done_o bit pulses.
- req_rnw_i  in  N_REQ  1 = read, 0 = write; per requester.
- req_slave_addr_i  in  8*N_REQ  slave address in 8-bit form, requester k at bits [8k+7:8k].
- req_command_byte_i  in  8*N_REQ  register/command byte.
- req_din_i  in  8*N_REQ  write data byte.
- req_num_bytes_i  in  8*N_REQ  byte count, including the command byte.
- grant_o  out  N_REQ  one-hot owner of the bus; all zero when idle.
- done_o  out  N_REQ  one-cycle completion pulse to the owner.
- err_o  out  1  valid while any done_o bit is high; 1 = transaction failed.
- rdata_o  out  8  last byte captured from the core; held until the next capture.
- i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_valid_i  in  1  status from the I2C core.
- i2c_data_out_i  in  8  read data from the core.
- i2c_write_o, i2c_read_o  out  1  one-cycle strobes to the core.
- i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o  out  8  transaction fields to the core.

Behaviour:
- Reset: all outputs are 0; state goes to IDLE; last_grant = N_REQ-1, so requester 0 wins first. Reset asserted mid-transaction aborts immediately with no done pulse.
- IDLE: if i2c_busy_i=0 and req_i!=0, choose the first set bit searching upward from last_grant+1 with wrap-around. Then:
  - register the grant into grant_o and last_grant;
  - latch that requester's rnw/addr/cmd/din/num_bytes into the i2c_* outputs;
  - go to ISSUE.
  - If i2c_busy_i=1 (foreign activity), stay in IDLE.
- ISSUE (1 cycle):
  - i2c_read_o=1 if rnw, else i2c_write_o=1; the other strobe stays 0.
  - Clear the timer and the sticky arb_err; go to WAIT_START.
- WAIT_START:
  - If i2c_busy_i=1, go to WAIT_END.
  - Otherwise increment the timer; when it reaches START_TIMEOUT, go to COMPLETE with tmo=1.
- WAIT_END:
  - i2c_arb_lost_i=1 in any cycle sets the sticky arb_err.
  - i2c_data_out_valid_i=1 captures i2c_data_out_i into rdata_o; on several valid cycles, the last one wins.
  - When i2c_busy_i=0, sample i2c_rxak_i into nack (also OR in arb_lost this cycle) and go to COMPLETE.
- COMPLETE (1 cycle, Moore):
  - done_o = grant_o.
  - err_o = tmo | arb_err | (nack & ~rnw). On a read, rxak=1 is the master's final NACK and is not an error.
  - Next state is IDLE, with grant_o cleared on entry to IDLE.
- Requester rule: deassert req_i on the clock edge at which done_o is seen; req_i is only sampled in IDLE. If a requester keeps req_i high, that counts as a new request, but round-robin order still applies.
- A requester dropping req_i while granted does not abort the transaction; done_o still pulses.
- The i2c_* field outputs hold their latched values from grant until the next grant; they do not track req_* inputs mid-transaction.
- Throughput: minimum 4 cycles per transaction plus the core's busy time.

Test Plan:
- Reset, then requester 0 writes addr 0xD0, cmd 0x6B, din 0x00, num 2; busy rises the cycle after the strobe, falls 5 cycles later, rxak=0 -> grant_o=01, exactly one i2c_write_o pulse, fields match, done_o=01, err_o=0.
- Requester 1 reads cmd 0x3D; valid data 0xF9 while busy, rxak=1 at busy fall -> i2c_read_o pulse, rdata_o=0xF9, done_o=10, err_o=0.
- req_i=11 held continuously for 4 transactions -> grants alternate 01, 10, 01, 10.
- Write with i2c_arb_lost_i pulsed mid-busy, or with rxak=1 at busy fall -> err_o=1 with done_o.
- Busy never rises after the strobe -> done_o pulses with err_o=1 exactly START_TIMEOUT cycles after the end of ISSUE.
- Assert reset_i during WAIT_END -> all outputs go to 0 asynchronously with no done pulse; the next request from requester 0 is granted first.
